// File: rtl/deco_escritura_picoblaze.sv
// PicoBlaze output-port decoder that launches RTC read/write transactions.
// Holds the address/data bytes, issues start pulses and tracks timeout and command errors.
module deco_escritura_picoblaze #(
  parameter int          TIMEOUT     = 255,
  parameter logic [7:0]  PUERTO_BASE = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       listo_lee,
  input  logic       listo_escribe,
  output logic [7:0] direccion,
  output logic [7:0] dato_escribe,
  output logic       inicia_lee,
  output logic       inicia_escribe,
  output logic       ocupado,
  output logic       error_cmd,
  output logic       error_tiempo
);

  localparam logic [7:0] PUERTO_DIR    = PUERTO_BASE;
  localparam logic [7:0] PUERTO_DATO   = PUERTO_BASE + 8'd1;
  localparam logic [7:0] PUERTO_CMD    = PUERTO_BASE + 8'd2;
  localparam logic [7:0] PUERTO_BORRA  = PUERTO_BASE + 8'd3;
  localparam logic [7:0] LIMITE        = 8'(TIMEOUT);

  typedef enum logic [1:0] {REPOSO, LEE, ESCRIBE} estado_t;

  estado_t    estado, estado_next;
  logic [7:0] cuenta, cuenta_next;
  logic       inicia_lee_next, inicia_escribe_next;
  logic       set_error_cmd, set_error_tiempo;

  logic wr_dir, wr_dato, wr_cmd, wr_borra;

  assign wr_dir   = write_strobe && (port_id == PUERTO_DIR);
  assign wr_dato  = write_strobe && (port_id == PUERTO_DATO);
  assign wr_cmd   = write_strobe && (port_id == PUERTO_CMD);
  assign wr_borra = write_strobe && (port_id == PUERTO_BORRA);

  assign ocupado = (estado != REPOSO);

  always_comb begin
    estado_next         = estado;
    cuenta_next         = 8'd0;
    inicia_lee_next     = 1'b0;
    inicia_escribe_next = 1'b0;
    set_error_cmd       = 1'b0;
    set_error_tiempo    = 1'b0;
    case (estado)
      REPOSO: begin
        if (wr_cmd) begin
          case (out_port[1:0])
            2'b01: begin
              estado_next     = LEE;
              inicia_lee_next = 1'b1;
            end
            2'b10: begin
              estado_next         = ESCRIBE;
              inicia_escribe_next = 1'b1;
            end
            default: set_error_cmd = 1'b1;
          endcase
        end
      end
      LEE, ESCRIBE: begin
        // Any command while busy is rejected, even on the completion cycle.
        set_error_cmd = wr_cmd;
        if ((estado == LEE) ? listo_lee : listo_escribe) begin
          estado_next = REPOSO;
        end else if (cuenta == LIMITE) begin
          estado_next      = REPOSO;
          set_error_tiempo = 1'b1;
        end else begin
          cuenta_next = cuenta + 8'd1;
        end
      end
      default: estado_next = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado         <= REPOSO;
      cuenta         <= 8'd0;
      direccion      <= 8'h00;
      dato_escribe   <= 8'h00;
      inicia_lee     <= 1'b0;
      inicia_escribe <= 1'b0;
      error_cmd      <= 1'b0;
      error_tiempo   <= 1'b0;
    end else begin
      estado         <= estado_next;
      cuenta         <= cuenta_next;
      inicia_lee     <= inicia_lee_next;
      inicia_escribe <= inicia_escribe_next;
      if (estado == REPOSO && wr_dir)  direccion    <= out_port;
      if (estado == REPOSO && wr_dato) dato_escribe <= out_port;
      // A new error event in the same cycle as a clear leaves the flag set.
      error_cmd    <= (error_cmd    & ~wr_borra) | set_error_cmd;
      error_tiempo <= (error_tiempo & ~wr_borra) | set_error_tiempo;
    end
  end

endmodule

// File: tb/tb_deco_escritura_picoblaze.sv
// Scoreboard bench: expected start pulses are queued when a command is issued
// and matched by a monitor; state and flag checks are made directly.
module tb_deco_escritura_picoblaze;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       listo_lee = 1'b0;
  logic       listo_escribe = 1'b0;
  logic [7:0] direccion, dato_escribe;
  logic       inicia_lee, inicia_escribe, ocupado, error_cmd, error_tiempo;

  deco_escritura_picoblaze dut (
    .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .listo_lee(listo_lee), .listo_escribe(listo_escribe),
    .direccion(direccion), .dato_escribe(dato_escribe), .inicia_lee(inicia_lee),
    .inicia_escribe(inicia_escribe), .ocupado(ocupado), .error_cmd(error_cmd),
    .error_tiempo(error_tiempo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         escribe;
    logic [7:0] dir;
    logic [7:0] dat;
  } pulso_t;

  pulso_t esperados[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Pulse monitor: each observed start pulse must match the oldest queued one.
  always @(negedge clk) begin
    if (inicia_lee || inicia_escribe) begin
      if (esperados.size() == 0) begin
        check("pulso_inesperado", {30'd0, inicia_escribe, inicia_lee}, 32'd0);
      end else begin
        pulso_t p;
        p = esperados.pop_front();
        check("pulso_tipo", {30'd0, inicia_escribe, inicia_lee},
              p.escribe ? 32'd2 : 32'd1);
        check("pulso_dir", {24'd0, direccion}, {24'd0, p.dir});
        check("pulso_dato", {24'd0, dato_escribe}, {24'd0, p.dat});
      end
    end
  end

  task automatic escribe_puerto(input logic [7:0] id, input logic [7:0] dat);
    @(negedge clk);
    port_id = id; out_port = dat; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0; port_id = 8'h00;
  endtask

  task automatic espera_pulso(input bit escribe, input logic [7:0] dir, input logic [7:0] dat);
    pulso_t p;
    p.escribe = escribe; p.dir = dir; p.dat = dat;
    esperados.push_back(p);
  endtask

  task automatic pulsa_listo(input bit escribe);
    @(negedge clk);
    if (escribe) listo_escribe = 1'b1; else listo_lee = 1'b1;
    @(negedge clk);
    listo_escribe = 1'b0; listo_lee = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_direccion", {24'd0, direccion}, 32'h00);
    check("rst_dato", {24'd0, dato_escribe}, 32'h00);
    check("rst_flags", {25'd0, inicia_lee, inicia_escribe, ocupado, error_cmd, error_tiempo}, 32'd0);
    rst = 1'b1;

    // Write transaction
    escribe_puerto(8'h01, 8'h21);
    check("carga_dir", {24'd0, direccion}, 32'h21);
    escribe_puerto(8'h02, 8'h45);
    check("carga_dato", {24'd0, dato_escribe}, 32'h45);
    escribe_puerto(8'h00, 8'hEE);
    escribe_puerto(8'h05, 8'hEE);
    check("puerto_ajeno", {16'd0, direccion, dato_escribe}, 32'h2145);
    espera_pulso(1'b1, 8'h21, 8'h45);
    escribe_puerto(8'h03, 8'h02);
    check("escribe_ocupado", {31'd0, ocupado}, 32'd1);
    @(negedge clk);
    check("escribe_pulso_fin", {31'd0, inicia_escribe}, 32'd0);
    pulsa_listo(1'b0);
    check("escribe_ignora_listo_lee", {31'd0, ocupado}, 32'd1);
    pulsa_listo(1'b1);
    check("escribe_fin", {31'd0, ocupado}, 32'd0);

    // Read with busy-time writes ignored, foreign completion and second command
    espera_pulso(1'b0, 8'h21, 8'h45);
    escribe_puerto(8'h03, 8'hFD);
    check("lee_ocupado", {31'd0, ocupado}, 32'd1);
    escribe_puerto(8'h01, 8'h33);
    check("dir_estable", {24'd0, direccion}, 32'h21);
    escribe_puerto(8'h02, 8'h77);
    check("dato_estable", {24'd0, dato_escribe}, 32'h45);
    pulsa_listo(1'b1);
    check("lee_ignora_listo_escribe", {31'd0, ocupado}, 32'd1);
    escribe_puerto(8'h03, 8'h02);
    check("cmd_ocupado_err", {30'd0, error_cmd, ocupado}, 32'd3);
    pulsa_listo(1'b0);
    check("lee_fin", {31'd0, ocupado}, 32'd0);
    escribe_puerto(8'h04, 8'h00);
    check("borra_err_cmd", {31'd0, error_cmd}, 32'd0);

    // Command in the same cycle as completion is rejected
    espera_pulso(1'b0, 8'h21, 8'h45);
    escribe_puerto(8'h03, 8'h01);
    @(negedge clk);
    listo_lee = 1'b1; port_id = 8'h03; out_port = 8'h01; write_strobe = 1'b1;
    @(negedge clk);
    listo_lee = 1'b0; write_strobe = 1'b0; port_id = 8'h00;
    check("cmd_con_listo", {30'd0, error_cmd, ocupado}, 32'd2);
    escribe_puerto(8'h04, 8'h5A);
    check("borra_cualquier_valor", {31'd0, error_cmd}, 32'd0);

    // Illegal command codes
    escribe_puerto(8'h03, 8'h03);
    check("cmd_11", {30'd0, error_cmd, ocupado}, 32'd2);
    escribe_puerto(8'h04, 8'hAA);
    check("borra_cmd_11", {31'd0, error_cmd}, 32'd0);
    escribe_puerto(8'h03, 8'hFC);
    check("cmd_00", {30'd0, error_cmd, ocupado}, 32'd2);
    escribe_puerto(8'h04, 8'h00);

    // Timeout, with a clear landing on the timeout cycle
    espera_pulso(1'b0, 8'h21, 8'h45);
    escribe_puerto(8'h03, 8'h01);
    repeat (254) @(negedge clk);
    check("antes_timeout", {30'd0, ocupado, error_tiempo}, 32'd2);
    escribe_puerto(8'h04, 8'h00);
    check("timeout", {29'd0, ocupado, error_tiempo, error_cmd}, 32'd2);
    escribe_puerto(8'h04, 8'h00);
    check("borra_timeout", {31'd0, error_tiempo}, 32'd0);

    // Completion on the timeout cycle wins
    espera_pulso(1'b0, 8'h21, 8'h45);
    escribe_puerto(8'h03, 8'h01);
    repeat (255) @(negedge clk);
    check("limite_ocupado", {31'd0, ocupado}, 32'd1);
    listo_lee = 1'b1;
    @(negedge clk);
    listo_lee = 1'b0;
    check("limite_listo", {30'd0, ocupado, error_tiempo}, 32'd0);

    // Reset in the middle of a write
    escribe_puerto(8'h01, 8'h5A);
    espera_pulso(1'b1, 8'h5A, 8'h45);
    escribe_puerto(8'h03, 8'h02);
    escribe_puerto(8'h03, 8'h01);
    check("pre_reset_err", {31'd0, error_cmd}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("reset_datos", {16'd0, direccion, dato_escribe}, 32'h0000);
    check("reset_flags", {25'd0, inicia_lee, inicia_escribe, ocupado, error_cmd, error_tiempo}, 32'd0);
    @(negedge clk);
    check("post_reset_flags", {29'd0, inicia_escribe, ocupado, error_tiempo}, 32'd0);
    espera_pulso(1'b0, 8'h00, 8'h00);
    escribe_puerto(8'h03, 8'h01);
    check("post_reset_cmd", {31'd0, ocupado}, 32'd1);
    pulsa_listo(1'b0);
    check("post_reset_fin", {31'd0, ocupado}, 32'd0);

    repeat (3) @(negedge clk);
    check("cola_vacia", esperados.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deco_escritura_picoblaze.md
DECO_ESCRITURA_PICOBLAZE -- requirements
Module: deco_escritura_picoblaze

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, meaning max clk cycles a transaction waits for its completion flag.
REQ-002 SHALL provide parameter PUERTO_BASE, default 8'h01, meaning port_id of the address register; data, command and error-clear ports are PUERTO_BASE+1, +2 and +3.
REQ-003 SHALL have port clk  input  1  the single system clock, with all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port port_id  input  8  PicoBlaze output port address.
REQ-006 SHALL have port out_port  input  8  PicoBlaze output data.
REQ-007 SHALL have port write_strobe  input  1  PicoBlaze write qualifier, 1 cycle.
REQ-008 SHALL have port listo_lee  input  1  RTC read completion flag from the RTC controller.
REQ-009 SHALL have port listo_escribe  input  1  RTC write completion flag from the RTC controller.
REQ-010 SHALL have port direccion  output  8  RTC register address held for the controller.
REQ-011 SHALL have port dato_escribe  output  8  data byte held for an RTC write.
REQ-012 SHALL have port inicia_lee  output  1  one-cycle read start pulse.
REQ-013 SHALL have port inicia_escribe  output  1  one-cycle write start pulse.
REQ-014 SHALL have port ocupado  output  1  transaction in progress.
REQ-015 SHALL have port error_cmd  output  1  sticky flag for an illegal or rejected command.
REQ-016 SHALL have port error_tiempo  output  1  sticky flag for a transaction timeout.

Function
REQ-017 SHALL decode a write as write_strobe=1 with port_id matching one of the four ports; every other port_id SHALL have no effect.
REQ-018 SHALL load direccion from out_port on an address-port write, with the new value visible the cycle after the strobe, only in REPOSO.
REQ-019 SHALL load dato_escribe from out_port on a data-port write, with the new value visible the cycle after the strobe, only in REPOSO.
REQ-020 SHALL ignore address-port and data-port writes outside REPOSO, so direccion and dato_escribe stay stable for the whole transaction.
REQ-021 SHALL implement an FSM with states REPOSO, LEE and ESCRIBE.
REQ-022 SHALL, on a command write in REPOSO with out_port[1:0]=01, go to LEE and assert inicia_lee for exactly the following cycle.
REQ-023 SHALL, on a command write in REPOSO with out_port[1:0]=10, go to ESCRIBE and assert inicia_escribe for exactly the following cycle.
REQ-024 SHALL, on a command write in REPOSO with out_port[1:0]=00 or 11, stay in REPOSO, generate no pulse and set error_cmd.
REQ-025 SHALL ignore out_port[7:2] on command writes.
REQ-026 SHALL, on any command write while in LEE or ESCRIBE, ignore the command and set error_cmd; this includes a command write in the same cycle that completion is sampled.
REQ-027 SHALL drive ocupado=1 exactly when the state is LEE or ESCRIBE.
REQ-028 SHALL, in LEE, return to REPOSO on the cycle after listo_lee=1 is sampled and ignore listo_escribe.
REQ-029 SHALL, in ESCRIBE, return to REPOSO on the cycle after listo_escribe=1 is sampled and ignore listo_lee.
REQ-030 SHALL ignore both completion flags in REPOSO.
REQ-031 SHALL use an 8-bit cycle counter that clears on entry to LEE or ESCRIBE and increments each cycle in those states.
REQ-032 SHALL, when the counter reaches TIMEOUT without the matching completion flag, return to REPOSO and set error_tiempo.
REQ-033 SHALL treat completion as winning when the matching flag and TIMEOUT occur in the same cycle, with error_tiempo not set.
REQ-034 SHALL clear both error_cmd and error_tiempo on an error-clear port write, in any state, regardless of out_port value.
REQ-035 SHALL give an error-clear write and a new error event in the same cycle the result of the flag set.
REQ-036 SHALL allow the next command to be accepted on the first cycle ocupado=0.

Reset
REQ-037 SHALL, when rst=0 at a rising edge, force the FSM to REPOSO and the counter to 0.
REQ-038 SHALL, when rst=0 at a rising edge, set direccion=8'h00, dato_escribe=8'h00 and all 1-bit outputs to 0.
REQ-039 SHALL treat reset mid-transaction as an abort, issuing no pulse and no error flag.

Verification
REQ-040 SHALL cover: write 8'h21 to 0x01 and 8'h45 to 0x02, then 8'h02 to 0x03 -> direccion=21, dato_escribe=45, one-cycle inicia_escribe, ocupado=1; listo_escribe -> ocupado=0 next cycle.
REQ-041 SHALL cover: read command 8'h01, then address write 8'h33 while busy, then listo_lee -> direccion unchanged, single inicia_lee pulse, return to REPOSO.
REQ-042 SHALL cover: command 8'h03 -> no pulse, error_cmd=1; write to 0x04 -> error_cmd=0.
REQ-043 SHALL cover: read command with no listo_lee -> error_tiempo=1 and ocupado=0 after TIMEOUT cycles; listo_lee at exactly TIMEOUT -> no error.
REQ-044 SHALL cover: second command while in LEE -> ignored, error_cmd=1, listo_escribe in LEE has no effect.
REQ-045 SHALL cover: rst=0 for one cycle mid-ESCRIBE -> all outputs 0 next cycle, no error flags, new command accepted afterward.
